uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter that shares the single `uart_tx` transmit channel among `NUM_REQ` byte-stream requesters. It sits between the client blocks (command responders, debug/log sources) and the `uart` wrapper's `uart_in`/`uart_in_valid`/`tx_ready` port. Grants are packet-atomic: a requester holds the channel until it marks a last byte or hits the burst limit, so bytes from different sources never interleave.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: maximum bytes per grant before forced release, 1..256.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset; **asynchronous, active-high**.
- `req_data`  in  `NUM_REQ*8`  byte from requester i on bits [8i+7:8i].
- `req_valid`  in  `NUM_REQ`  requester i has a byte.
- `req_last`  in  `NUM_REQ`  byte from requester i is the last byte of its packet.
- `req_ready`  out  `NUM_REQ`  byte from requester i accepted this cycle.
- `uart_in`  out  8  byte to `uart_tx`.
- `uart_in_valid`  out  1  byte valid to `uart_tx`.
- `tx_ready`  in  1  `uart_tx` can accept a byte.
- `grant_id`  out  `$clog2(NUM_REQ)`  index of the current owner; holds its last value while idle.
- `busy`  out  1  a grant is active (state ≠ IDLE).

## Operation

- FSM states: IDLE, TAG (present only with `UART_ARB_TAG_EN`), XFER.
- Handshakes: a byte transfers on any cycle with `valid && ready` high. `req_ready[i] = (state==XFER) && (grant_id==i) && tx_ready`. All other `req_ready` bits are 0.
- IDLE: if any `req_valid` is high, select the first set bit scanning from `last_grant+1` upward with wrap-around, load `grant_id`, clear `burst_cnt`, go to TAG or XFER. If none is high, stay in IDLE.
- XFER: `uart_in = req_data[grant_id]` and `uart_in_valid = req_valid[grant_id]`, combinational pass-through. On each transfer, `burst_cnt` increments. The block releases to IDLE and sets `last_grant = grant_id` on either of these transfers:
  - a transfer with `req_last[grant_id]=1`;
  - the transfer that makes `burst_cnt == MAX_BURST` (forced release).
- When the owner drops `req_valid` mid-packet, the grant is held indefinitely. There is no timeout.
- `burst_cnt` width is `$clog2(MAX_BURST+1)`. It never exceeds `MAX_BURST`.
- Reset values:
  - `uart_in=0`, `uart_in_valid=0`, `req_ready=0`, `busy=0`, `grant_id=0`;
  - state=IDLE, `burst_cnt=0`;
  - `last_grant=NUM_REQ-1`, so requester 0 has first priority after reset.
- Reset mid-packet aborts the grant immediately. The remaining bytes are not sent, and the requester must resend.
- Simultaneous requests are resolved purely by the round-robin pointer. A newly asserted `req_valid` never preempts the current owner.

## Timing

- Arbitration costs 1 cycle. The request is seen in IDLE at cycle N, `grant_id`/`busy` are valid at N+1, and the first byte can transfer at N+1 (no TAG) or N+2 (TAG).
- Release costs 1 cycle. After the last transfer at cycle M, the block is in IDLE at M+1 and the next owner is granted at M+2. Back-to-back packets therefore have at least 1 idle cycle on `uart_in_valid`.
- Throughput is limited only by `tx_ready`. At 115200 baud, each byte occupies `uart_tx` for about 4340 cycles.
- `req_data`, `req_valid` and `req_last` must be stable from assertion until `req_ready` (AXI-stream style). The arbiter does not register them.

## Configuration

- `UART_ARB_TAG_EN` defined:
  - Each grant enters TAG after IDLE.
  - TAG drives `uart_in = 8'hA0 | grant_id` with `uart_in_valid=1` and `req_ready=0`.
  - On the `tx_ready` handshake it moves to XFER.
  - The tag does not count toward `burst_cnt`.
  - A forced release followed by a re-grant emits a new tag.
- `UART_ARB_TAG_EN` not defined: no TAG state; IDLE goes directly to XFER. The output stream is the raw concatenation of packets.

## Test plan

- Reset release, all `req_valid=0`, held for 100 cycles -> `busy=0`, `uart_in_valid=0`, `req_ready=0` throughout.
- Req 2 sends 3 bytes 0x11/0x22/0x33 with `req_last` on 0x33, `tx_ready` toggling -> `uart_in` carries exactly 11,22,33 in order (prefixed by 0xA2 with TAG_EN). `busy` drops 1 cycle after the 0x33 handshake.
- Reqs 0, 1 and 3 all valid from reset, 2-byte packets each -> grant order 0,1,3,0,… with no interleaving inside a packet.
- `MAX_BURST=4`, req 1 streams 10 bytes with no `req_last` while req 2 is waiting -> after 4 bytes the grant passes to req 2, then returns to req 1.
- `rst` asserted for 1 cycle after the 2nd byte of a 5-byte packet -> outputs return to reset values asynchronously. The next grant goes to the lowest valid index (0 before 1).
- With TAG_EN, `tx_ready=0` for 50 cycles in TAG -> `uart_in=0xA0|grant_id` is held stable and `req_ready` stays 0 until `tx_ready` rises.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Packet-atomic round-robin arbiter sharing one uart_tx byte channel among NUM_REQ requesters.
// Define UART_ARB_TAG_EN to prefix every grant with an 8'hA0|grant_id tag byte.
module uart_tx_arb #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 uart_in,
  output logic                       uart_in_valid,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {IDLE, TAG, XFER} state_e;
`else
  typedef enum logic [0:0] {IDLE, XFER} state_e;
`endif

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0]  burst_cnt_q, burst_cnt_d;

  logic [7:0]     req_byte [NUM_REQ];
  logic [IDW-1:0] pick;
  logic [IDW-1:0] idx;
  logic           pick_vld;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_byte[g] = req_data[8*g +: 8];
  end

  // First valid requester strictly after the previous owner, wrapping around.
  always_comb begin
    pick     = last_grant_q;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!pick_vld && req_valid[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    burst_cnt_d   = burst_cnt_q;
    uart_in       = '0;
    uart_in_valid = 1'b0;
    req_ready     = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_id_d  = pick;
          burst_cnt_d = '0;
`ifdef UART_ARB_TAG_EN
          state_d     = TAG;
`else
          state_d     = XFER;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        uart_in       = 8'hA0 | 8'(grant_id_q);
        uart_in_valid = 1'b1;
        if (tx_ready) state_d = XFER;
      end
`endif
      XFER: begin
        uart_in               = req_byte[grant_id_q];
        uart_in_valid         = req_valid[grant_id_q];
        req_ready[grant_id_q] = tx_ready;
        if (req_valid[grant_id_q] && tx_ready) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
          // Release on end of packet or on the byte that reaches the burst cap.
          if (req_last[grant_id_q] || (burst_cnt_q == CW'(MAX_BURST - 1))) begin
            state_d      = IDLE;
            last_grant_d = grant_id_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized and directed bench for uart_tx_arb against a queue-based reference model.
// Honours UART_ARB_TAG_EN for the tag-byte expectations.
module tb_uart_tx_arb;
  localparam int N  = 4;
  localparam int MB = 4;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic           clk, rst;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [7:0]     uart_in;
  logic           uart_in_valid, tx_ready;
  logic [1:0]     grant_id;
  logic           busy;

  uart_tx_arb #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .uart_in(uart_in),
    .uart_in_valid(uart_in_valid), .tx_ready(tx_ready), .grant_id(grant_id),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [7:0] qd [N][256];
  bit         ql [N][256];
  int         qh [N], qt [N], pops [N];
  bit         pres [N];
  int         gap_pct, tx_mode;
  // Reference model: owner is -1 when nobody holds the channel.
  int         m_owner, m_last, m_gid, m_cnt;
  bit         m_tag;
  logic [7:0] stream [$];
  int         grants [$];
  bit         prev_busy;
  int         fall_cyc, last_hs_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit l);
    if (qt[i] < 256) begin
      qd[i][qt[i]] = d;
      ql[i][qt[i]] = l;
      qt[i]++;
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_gid = 0; m_cnt = 0; m_tag = 1'b0;
  endtask

  function automatic bit all_done();
    bit d;
    d = (m_owner < 0);
    for (int i = 0; i < N; i++) if (qh[i] != qt[i] || pres[i]) d = 1'b0;
    return d;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && qh[i] < qt[i] && $urandom_range(99) < gap_pct) pres[i] = 1'b1;
      req_valid[i] = pres[i];
      if (pres[i]) begin
        req_data[8*i +: 8] = qd[i][qh[i]];
        req_last[i]        = ql[i][qh[i]];
      end else begin
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
    case (tx_mode)
      0:       tx_ready = 1'($urandom);
      1:       tx_ready = ~tx_ready;
      2:       tx_ready = 1'b1;
      default: tx_ready = 1'b0;
    endcase
  endtask

  task automatic model_advance();
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (req_valid[c]) begin
          m_owner = c; m_gid = c; m_cnt = 0; m_tag = TAG_EN;
          break;
        end
      end
    end else if (m_tag) begin
      if (tx_ready) m_tag = 1'b0;
    end else if (req_valid[m_owner] && tx_ready) begin
      m_cnt++;
      if (req_last[m_owner] || m_cnt == MB) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic cycle();
    logic       e_busy, e_vld;
    logic [7:0] e_dat;
    logic [N-1:0] e_rdy;
    @(negedge clk);
    drive_inputs();
    #1;
    e_busy = (m_owner >= 0);
    e_vld  = 1'b0; e_dat = 8'h00; e_rdy = '0;
    if (m_owner >= 0 && m_tag) begin
      e_vld = 1'b1; e_dat = 8'hA0 | 8'(m_owner);
    end else if (m_owner >= 0) begin
      e_vld = req_valid[m_owner]; e_dat = req_data[8*m_owner +: 8];
      e_rdy[m_owner] = tx_ready;
    end
    chk("busy", busy, e_busy);
    chk("grant_id", grant_id, m_gid);
    chk("uart_in_valid", uart_in_valid, e_vld);
    if (e_vld) chk("uart_in", uart_in, e_dat);
    chk("req_ready", req_ready, e_rdy);
    if (busy && !prev_busy) grants.push_back(int'(grant_id));
    if (!busy && prev_busy) fall_cyc = cyc;
    prev_busy = busy;
    if (uart_in_valid && tx_ready) begin
      stream.push_back(uart_in);
      last_hs_cyc = cyc;
    end
    for (int i = 0; i < N; i++)
      if (e_rdy[i] && req_valid[i]) begin
        qh[i]++; pops[i]++; pres[i] = 1'b0;
      end
    model_advance();
    cyc++;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (!all_done() && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_within_budget", all_done(), 1);
    repeat (2) cycle();
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_uart_in_valid", uart_in_valid, 0);
    chk("rst_uart_in", uart_in, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    model_reset();
    prev_busy = 1'b0;
    repeat (ncyc) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic chk_grants(input string nm, input int exp [$]);
    chk({nm, "_count"}, grants.size(), exp.size());
    for (int i = 0; i < exp.size() && i < grants.size(); i++) chk(nm, grants[i], exp[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0;
    int exp_g [$];
    logic [7:0] exp_s [$];
    rst = 1'b1; req_data = '0; req_valid = '0; req_last = '0; tx_ready = 1'b0;
    for (int i = 0; i < N; i++) begin qh[i] = 0; qt[i] = 0; pops[i] = 0; pres[i] = 1'b0; end
    gap_pct = 100; tx_mode = 2; fall_cyc = -1; last_hs_cyc = -1;
    model_reset();
    do_reset(3);

    // Idle after reset: nothing may move for 100 cycles.
    repeat (100) begin
      cycle();
      chk("idle_busy", busy, 0);
      chk("idle_uart_in_valid", uart_in_valid, 0);
      chk("idle_req_ready", req_ready, 0);
    end

    // Requester 2 sends 11,22,33 with a toggling tx_ready.
    stream.delete();
    push(2, 8'h11, 0); push(2, 8'h22, 0); push(2, 8'h33, 1);
    tx_mode = 1;
    run_until_done(60);
`ifdef UART_ARB_TAG_EN
    exp_s = '{8'hA2, 8'h11, 8'h22, 8'h33};
`else
    exp_s = '{8'h11, 8'h22, 8'h33};
`endif
    chk("req2_stream_len", stream.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < stream.size(); i++) chk("req2_stream_byte", stream[i], exp_s[i]);
    chk("busy_fall_after_last", fall_cyc, last_hs_cyc + 1);

    // Requesters 0,1,3 contend from reset with 2-byte packets.
    do_reset(1);
    grants.delete();
    for (int p = 0; p < 2; p++)
      foreach (exp_g[j]) ;
    for (int p = 0; p < 2; p++) begin
      push(0, 8'(8'h00 + p*4), 0); push(0, 8'(8'h01 + p*4), 1);
      push(1, 8'(8'h10 + p*4), 0); push(1, 8'(8'h11 + p*4), 1);
      push(3, 8'(8'h30 + p*4), 0); push(3, 8'(8'h31 + p*4), 1);
    end
    tx_mode = 2;
    run_until_done(100);
    exp_g = '{0, 1, 3, 0, 1, 3};
    chk_grants("rr_order", exp_g);

    // Requester 1 streams without a last byte while requester 2 waits.
    grants.delete();
    for (int k = 0; k < 10; k++) push(1, 8'(8'h40 + k), 0);
    push(2, 8'h50, 0); push(2, 8'h51, 1);
    n = 0;
    while ((qh[1] != qt[1] || pres[1] || qh[2] != qt[2] || pres[2]) && n < 200) begin
      cycle(); n++;
    end
    chk("burst_drain_within_budget", n < 200, 1);
    repeat (30) begin
      cycle();
      chk("hold_busy", busy, 1);
      chk("hold_grant_id", grant_id, 1);
    end
    push(1, 8'h4A, 1);
    run_until_done(50);
    exp_g = '{1, 2, 1, 1};
    chk_grants("burst_order", exp_g);

    // Reset after the 2nd byte of a 5-byte packet from requester 1.
    for (int k = 0; k < 5; k++) push(1, 8'(8'h60 + k), k == 4);
    p0 = pops[1]; n = 0;
    while (pops[1] - p0 < 2 && n < 40) begin
      cycle(); n++;
    end
    chk("midpkt_reach_within_budget", pops[1] - p0, 2);
    push(0, 8'h70, 1);
    grants.delete();
    do_reset(1);
    run_until_done(60);
    exp_g = '{0, 1};
    chk_grants("post_reset_order", exp_g);

`ifdef UART_ARB_TAG_EN
    // Tag byte must hold steady while the UART stalls.
    push(3, 8'h80, 1);
    tx_mode = 3;
    n = 0;
    while (!busy && n < 10) begin
      cycle(); n++;
    end
    repeat (50) begin
      cycle();
      chk("tag_uart_in", uart_in, 8'hA3);
      chk("tag_uart_in_valid", uart_in_valid, 1);
      chk("tag_req_ready", req_ready, 0);
    end
    tx_mode = 2;
    run_until_done(50);
`endif

    // Random traffic: packets of 1..6 bytes, some beyond the burst cap.
    tx_mode = 0; gap_pct = 60;
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 30; p++) begin
        int len;
        len = int'($urandom_range(1, 6));
        for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
      end
    run_until_done(20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
